// File: rtl/hold_slot_ctrl.sv
// hold_slot_ctrl: owns the Tetris hold slot.
// A hold press swaps the falling piece with the held one. When the slot is
// empty, the falling piece is parked and a fresh piece is fetched from the
// generator instead. Only one hold is allowed per drop. The replacement piece
// goes to the spawn logic over a valid/ready handshake. A rejected press makes
// the hold block blink for a while.
module hold_slot_ctrl #(
    parameter int                 PIECE_W     = 3,
    parameter logic [PIECE_W-1:0] EMPTY_CODE  = '0,
    parameter int                 DENY_CYCLES = 25_000_000,
    parameter int                 FLASH_DIV   = 6_250_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               hold_btn,
    input  logic [PIECE_W-1:0] cur_piece,
    input  logic               cur_valid,
    input  logic               piece_locked,
    output logic               next_req,
    input  logic               next_valid,
    input  logic [PIECE_W-1:0] next_piece,
    output logic               spawn_valid,
    input  logic               spawn_ready,
    output logic [PIECE_W-1:0] spawn_piece,
    output logic [PIECE_W-1:0] hold_piece,
    output logic               hold_view,
    output logic               hold_used,
    output logic               hold_denied,
    output logic               busy
);

    // Counter widths are sized so that the full load value fits.
    localparam int DCW = $clog2(DENY_CYCLES + 1);
    localparam int FCW = $clog2(FLASH_DIV + 1);

    localparam logic [DCW-1:0] DENY_LOAD  = DCW'(DENY_CYCLES);
    localparam logic [FCW-1:0] FLASH_LAST = FCW'(FLASH_DIV - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_REQ_NEXT = 2'd1;
    localparam logic [1:0] ST_SPAWN    = 2'd2;

    logic [1:0]         state_q,       state_d;
    logic               btn_q,         btn_d;
    logic [PIECE_W-1:0] hold_piece_q,  hold_piece_d;
    logic [PIECE_W-1:0] spawn_piece_q, spawn_piece_d;
    logic               spawn_valid_q, spawn_valid_d;
    logic               next_req_q,    next_req_d;
    logic               hold_used_q,   hold_used_d;
    logic               hold_denied_q, hold_denied_d;
    logic [DCW-1:0]     deny_cnt_q,    deny_cnt_d;
    logic [FCW-1:0]     flash_cnt_q,   flash_cnt_d;
    logic               toggle_q,      toggle_d;
    logic               hold_view_q,   hold_view_d;

    logic               press;
    logic               deny_load;

    // Hold-slot FSM: press qualification, swap/fetch sequencing and the spawn handshake.
    always_comb begin
        state_d       = state_q;
        btn_d         = hold_btn;
        hold_piece_d  = hold_piece_q;
        spawn_piece_d = spawn_piece_q;
        spawn_valid_d = spawn_valid_q;
        next_req_d    = next_req_q;
        hold_used_d   = hold_used_q;
        hold_denied_d = 1'b0;
        deny_load     = 1'b0;
        // Rising edge of the debounced key, so a held key counts only once.
        press         = hold_btn & ~btn_q;

        case (state_q)
            ST_IDLE: begin
                // A lock can only legally arrive between swaps, so it is
                // honoured here and nowhere else.
                if (piece_locked) begin
                    hold_used_d = 1'b0;
                end
                if (press) begin
                    if (hold_used_q) begin
                        hold_denied_d = 1'b1;
                        deny_load     = 1'b1;
                    end else if (cur_valid && (cur_piece != EMPTY_CODE)) begin
                        hold_piece_d = cur_piece;
                        if (hold_piece_q == EMPTY_CODE) begin
                            // Empty slot: park the piece and ask for a fresh one.
                            next_req_d = 1'b1;
                            state_d    = ST_REQ_NEXT;
                        end else begin
                            // Occupied slot: the held piece comes straight back.
                            spawn_piece_d = hold_piece_q;
                            spawn_valid_d = 1'b1;
                            state_d       = ST_SPAWN;
                        end
                    end
                end
            end

            ST_REQ_NEXT: begin
                // An empty code from the generator is not a usable piece.
                if (next_valid && (next_piece != EMPTY_CODE)) begin
                    spawn_piece_d = next_piece;
                    next_req_d    = 1'b0;
                    spawn_valid_d = 1'b1;
                    state_d       = ST_SPAWN;
                end
            end

            ST_SPAWN: begin
                // spawn_piece is held until the spawn logic takes it.
                if (spawn_ready) begin
                    spawn_valid_d = 1'b0;
                    hold_used_d   = 1'b1;
                    state_d       = ST_IDLE;
                end
            end

            default: begin
                next_req_d    = 1'b0;
                spawn_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    // Deny-flash timing and the registered hold-block display enable.
    always_comb begin
        deny_cnt_d  = deny_cnt_q;
        flash_cnt_d = flash_cnt_q;
        toggle_d    = toggle_q;

        if (deny_load) begin
            // A fresh rejection restarts the blink in its visible phase.
            deny_cnt_d  = DENY_LOAD;
            flash_cnt_d = '0;
            toggle_d    = 1'b1;
        end else if (deny_cnt_q != '0) begin
            deny_cnt_d = deny_cnt_q - 1'b1;
            if (flash_cnt_q >= FLASH_LAST) begin
                flash_cnt_d = '0;
                toggle_d    = ~toggle_q;
            end else begin
                flash_cnt_d = flash_cnt_q + 1'b1;
            end
        end

        // Computed from next-state values so the display tracks hold_piece exactly.
        hold_view_d = (hold_piece_d != EMPTY_CODE) &&
                      ((deny_cnt_d == '0) || toggle_d);
    end

    // State registers: asynchronous reset, then the new-game clear, then normal update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            btn_q         <= 1'b0;
            hold_piece_q  <= EMPTY_CODE;
            spawn_piece_q <= EMPTY_CODE;
            spawn_valid_q <= 1'b0;
            next_req_q    <= 1'b0;
            hold_used_q   <= 1'b0;
            hold_denied_q <= 1'b0;
            deny_cnt_q    <= '0;
            flash_cnt_q   <= '0;
            toggle_q      <= 1'b0;
            hold_view_q   <= 1'b0;
        end else if (clear) begin
            state_q       <= ST_IDLE;
            btn_q         <= 1'b0;
            hold_piece_q  <= EMPTY_CODE;
            spawn_piece_q <= EMPTY_CODE;
            spawn_valid_q <= 1'b0;
            next_req_q    <= 1'b0;
            hold_used_q   <= 1'b0;
            hold_denied_q <= 1'b0;
            deny_cnt_q    <= '0;
            flash_cnt_q   <= '0;
            toggle_q      <= 1'b0;
            hold_view_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            btn_q         <= btn_d;
            hold_piece_q  <= hold_piece_d;
            spawn_piece_q <= spawn_piece_d;
            spawn_valid_q <= spawn_valid_d;
            next_req_q    <= next_req_d;
            hold_used_q   <= hold_used_d;
            hold_denied_q <= hold_denied_d;
            deny_cnt_q    <= deny_cnt_d;
            flash_cnt_q   <= flash_cnt_d;
            toggle_q      <= toggle_d;
            hold_view_q   <= hold_view_d;
        end
    end

    assign next_req    = next_req_q;
    assign spawn_valid = spawn_valid_q;
    assign spawn_piece = spawn_piece_q;
    assign hold_piece  = hold_piece_q;
    assign hold_view   = hold_view_q;
    assign hold_used   = hold_used_q;
    assign hold_denied = hold_denied_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: doc/hold_slot_ctrl.md
Name: hold_slot_ctrl

Overview:
- Owns the Tetris "hold" slot.
- On a hold request it swaps the falling piece with the held piece. If the slot is empty, it parks the falling piece and fetches a fresh piece from the piece generator instead.
- It enforces one hold per drop and hands the new piece to the spawn logic through a valid/ready handshake.
- Its hold_piece/hold_view outputs drive the hold-block pixel mapper on the side panel.

Parameters:
- PIECE_W, 3, piece code width; equals `BITS_PER_BLOCK.
- EMPTY_CODE, 0, piece code meaning "no piece" (`EMPTY_BLOCK); valid codes are 1..7 (I,O,T,S,Z,J,L).
- DENY_CYCLES, 25_000_000, length of the deny-flash window in clk cycles; must be ≥2.
- FLASH_DIV, 6_250_000, cycles per half-period of the deny flash.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- clear  input  1  synchronous new-game clear; active high.
- hold_btn  input  1  debounced hold key, level.
- cur_piece  input  PIECE_W  code of the currently falling piece.
- cur_valid  input  1  a piece is falling and may be held.
- piece_locked  input  1  one-cycle pulse: the falling piece has locked.
- next_req  output  1  request to the piece generator.
- next_valid  input  1  generator has next_piece ready.
- next_piece  input  PIECE_W  generator output.
- spawn_valid  output  1  spawn_piece must be spawned.
- spawn_ready  input  1  spawn logic accepts spawn_piece.
- spawn_piece  output  PIECE_W  piece to spawn.
- hold_piece  output  PIECE_W  held piece, to the hold-block mapper.
- hold_view  output  1  display enable for the hold block.
- hold_used  output  1  hold already used for this drop.
- hold_denied  output  1  one-cycle pulse: a press was rejected.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (rst_n=0, async) sets every register and output to 0 / EMPTY_CODE, state IDLE. `clear` does the same synchronously and has priority over all other inputs.
- Press detection:
  - press = hold_btn & ~btn_q; btn_q is a 1-bit register of hold_btn.
  - A held key yields exactly one press.
  - Presses while busy are dropped with no deny pulse.
- States: IDLE, REQ_NEXT, SPAWN.
- IDLE:
  - Press with cur_valid=1, cur_piece≠EMPTY and hold_used=0:
    - If hold_piece==EMPTY: hold_piece←cur_piece, go to REQ_NEXT.
    - Otherwise: spawn_piece←hold_piece, hold_piece←cur_piece, go to SPAWN.
  - Press with hold_used=1: hold_denied=1 for 1 cycle; deny counter loads DENY_CYCLES.
  - Press with cur_valid=0 or cur_piece==EMPTY: ignored silently.
- REQ_NEXT:
  - next_req=1 (registered, asserted from the cycle after entry).
  - On next_valid=1 sampled: spawn_piece←next_piece, next_req←0, go to SPAWN.
  - next_piece==EMPTY while next_valid=1 is not accepted; keep waiting.
- SPAWN:
  - spawn_valid=1.
  - spawn_piece stays stable until spawn_ready=1 sampled.
  - On handshake: spawn_valid←0, hold_used←1, go to IDLE.
- hold_used:
  - Cleared by piece_locked=1, but only when in IDLE.
  - piece_locked in REQ_NEXT/SPAWN is ignored, since a lock cannot legally occur mid-swap.
- Latency:
  - Press to spawn_valid (non-empty slot): 1 cycle.
  - Empty slot: next_req rises 1 cycle after the press; spawn_valid rises 1 cycle after next_valid.
- Deny flash:
  - While the deny counter > 0, it decrements each cycle.
  - A flash toggle flips every FLASH_DIV cycles.
  - A new deny press reloads the counter; the toggle restarts at 1.
- hold_view:
  - hold_view = (hold_piece≠EMPTY) & (deny_cnt==0 | toggle). The slot blinks while denied and is steady otherwise.
  - hold_view is registered.
- busy = (state≠IDLE).
- Async reset mid-swap abandons the swap: no spawn_valid and no next_req afterwards.

Test Plan:
- Reset/clear: drive hold_piece to 3 (T) via a swap, then pulse clear → all outputs 0; hold_piece=0; busy=0 next cycle.
- Empty-slot hold: cur_piece=1, cur_valid=1, press → hold_piece=1, next_req=1.
  - Generator returns next_valid=1, next_piece=5 after 4 cycles → spawn_valid=1, spawn_piece=5.
  - spawn_ready=1 → hold_used=1, busy=0.
- Swap: hold_piece=5, hold_used=0, cur_piece=7, press → next cycle spawn_valid=1, spawn_piece=5, hold_piece=7.
  - Hold spawn_ready=0 for 10 cycles → spawn_piece stays 5.
- Deny: hold_used=1, press → hold_denied pulses exactly 1 cycle.
  - hold_view toggles every FLASH_DIV cycles for DENY_CYCLES cycles, then returns steady 1 (use small parameters, e.g. DENY_CYCLES=40, FLASH_DIV=5).
  - A piece_locked pulse then clears hold_used, and the next press is accepted.
- Held key / busy presses: keep hold_btn high for 20 cycles → one swap only. Press again during REQ_NEXT → no effect, no deny pulse.
- Async reset asserted in SPAWN → spawn_valid drops immediately; after release, state IDLE and hold_piece=0.
